// File: rtl/async_transmitter.sv
// async_transmitter: 8N1 UART transmitter with a small input FIFO.
// Frames are sent LSB-first, back-to-back when more bytes are queued.
module async_transmitter #(
  parameter int OVERSAMPLE = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_uart,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TMR_MAX = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic push;
  logic pop;
  logic empty;
  logic tick;
  logic [7:0] head;

  assign ready = (count_q < CNT_MAX);
  assign empty = (count_q == '0);
  assign busy  = (state_q != S_IDLE) || !empty;
  assign tx    = tx_q;
  assign push  = send && ready;
  assign tick  = (tmr_q == TMR_MAX);
  assign head  = mem_q[rptr_q];

  // Framing FSM: next state, bit timer, shifter and line value.
  always_comb begin
    state_d = state_q;
    tmr_d   = tick ? '0 : tmr_q + TMR_ONE;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        tmr_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; push and pop together cancel.
  always_comb begin
    wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset abandons any frame and flushes the FIFO.
  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_uart) begin
    if (push && !rst) begin
      mem_q[wptr_q] <= data;
    end
  end

endmodule
